rnn_result_tx: RTL and testbench
================================

Name: rnn_result_tx

Overview:
- Transmit end of the denoiser's host serial link; the receive side carries feature bytes in, this block carries results out.
- Captures one RNN output frame (per-band gains plus VAD) with a valid/ready handshake.
- Serialises the frame as a fixed byte packet over a UART 8N1 line to the host.
- Sits after the RNN top, driving the board's UART TX pin.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- NUM_GAINS, 22, number of band gains per frame.
- GAIN_W, 8, width of each gain and of the VAD value; fixed at 8, other values unsupported.
- HDR_BYTE, 8'hA5, packet header byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- result_valid  input  1  gains/vad hold a new frame.
- result_ready  output  1  block can accept a frame.
- gains  input  NUM_GAINS*GAIN_W  gain i at bits [i*GAIN_W +: GAIN_W].
- vad  input  GAIN_W  voice-activity probability.
- uart_tx  output  1  serial line, idle high.
- busy  output  1  packet in progress.
- frame_done  output  1  one-cycle pulse when a packet's last stop bit ends.

Behaviour:
- Reset (async, rst_n low): uart_tx=1, busy=0, frame_done=0, result_ready=0 while in reset, then 1. All counters are 0 and state is IDLE. Any packet in flight is abandoned; there is no partial-byte completion.
- result_ready = (state==IDLE), combinational from state.
- Capture: on a clk edge with result_valid && result_ready, latch vad and all gains into an internal buffer. The bus inputs are don't-care afterwards.
- Packet byte order:
  - byte 0 = HDR_BYTE
  - byte 1 = vad
  - bytes 2..NUM_GAINS+1 = gain 0..NUM_GAINS-1
  - Total 24 bytes at the defaults.
- UART framing:
  - Per byte: start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly CLK_DIV cycles.
  - No idle gap between bytes.
- FSM states:
  - IDLE: uart_tx=1, busy=0. On capture go to START, byte_idx=0.
  - START: uart_tx=0 for CLK_DIV cycles, then DATA with bit_idx=0.
  - DATA: uart_tx=shift[bit_idx]. After CLK_DIV cycles, bit_idx++; after bit 7 go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles. If byte_idx==last, pulse frame_done and go to IDLE. Otherwise byte_idx++ and go to START.
- Timing:
  - First start bit appears on uart_tx the cycle after the capture edge.
  - Packet length = 24*10*CLK_DIV cycles; busy is high for exactly that span.
- Baud counter counts 0..CLK_DIV-1 and wraps on each bit boundary. It is reset to 0 on capture.
- Simultaneous events:
  - frame_done and result_valid in the same cycle: no capture (ready is still 0). Capture can occur the next cycle at the earliest.
  - result_valid while busy is ignored; no queuing and no error flag. The producer must hold valid.
- Throughput is bounded by the packet time. The RNN frame rate must stay below it; this is enforced upstream.

Optional Feature:
- Macro: RNN_TX_CHECKSUM_EN.
- Defined: one extra trailing byte is sent, equal to the XOR of bytes 0..NUM_GAINS+1. Packet becomes 25 bytes and frame_done follows that byte's stop bit.
- Undefined: 24-byte packet with no checksum logic.

Test Plan:
- Reset idle: hold rst_n=0 for 5 cycles, release -> uart_tx=1, busy=0, frame_done=0, result_ready=1 on the first cycle after release.
- Single packet (CLK_DIV=4): vad=8'h3C, gain i=i+1 -> decoded bytes A5,3C,01,02,...,16. frame_done pulses exactly 960 cycles after capture; busy is high for those 960 cycles.
- Bit timing (CLK_DIV=4): gains all 8'hFF, vad=8'h00 -> vad byte shows start plus 8 zero bits (36 low cycles), then 4 high stop cycles. Each gain byte shows exactly 4 low cycles, then 36 high.
- Back-pressure: pulse result_valid with new data mid-packet -> ignored, transmitted bytes are unchanged. Valid held in the frame_done cycle is captured on the following cycle, and the next start bit follows one cycle after that.
- Reset mid-packet: assert rst_n low during DATA of byte 5 -> uart_tx=1 and busy=0 immediately (asynchronously). After release, a new capture sends a full packet starting at A5.
- With RNN_TX_CHECKSUM_EN: the single-packet data above -> 25th byte = A5^3C^(XOR of 01..16); frame_done at 1000 cycles.

Source files
------------

// File: rtl/rnn_result_tx.sv
// rnn_result_tx: serialises one captured RNN result frame (header, vad, band gains) onto a UART 8N1 line.
// Latency: first start bit drives uart_tx the cycle after the capture edge; a packet lasts NUM_BYTES*10*CLK_DIV cycles.
// Backpressure: result_ready is high only while idle; valid offered while a packet is in flight is ignored, not queued.
// Optional feature: define RNN_TX_CHECKSUM_EN to append an XOR checksum byte covering all preceding packet bytes.
module rnn_result_tx #(
  parameter int          CLK_DIV   = 868,
  parameter int          NUM_GAINS = 22,
  parameter int          GAIN_W    = 8,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          result_valid,
  output logic                          result_ready,
  input  logic [NUM_GAINS*GAIN_W-1:0]   gains,
  input  logic [GAIN_W-1:0]             vad,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          frame_done
);

  // Header + vad + gains, plus one checksum byte when enabled.
  localparam int NUM_DATA  = NUM_GAINS + 2;
`ifdef RNN_TX_CHECKSUM_EN
  localparam int NUM_BYTES = NUM_DATA + 1;
`else
  localparam int NUM_BYTES = NUM_DATA;
`endif
  localparam int BIDX_W = $clog2(NUM_BYTES);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                        state, state_nx;
  logic [BAUD_W-1:0]             baud_cnt, baud_nx;
  logic [2:0]                    bit_idx, bit_nx;
  logic [BIDX_W-1:0]             byte_idx, byte_nx;
  logic [GAIN_W-1:0]             shift_q;
  logic [GAIN_W-1:0]             vad_q;
  logic [NUM_GAINS*GAIN_W-1:0]   gains_q;
  logic                          rdy_en;
  logic                          load_frame;
  logic                          load_shift;
  logic [GAIN_W-1:0]             byte_sel;
  logic                          baud_wrap;

`ifdef RNN_TX_CHECKSUM_EN
  logic [GAIN_W-1:0]             csum_in;
  logic [GAIN_W-1:0]             csum_q;

  // XOR of every byte that precedes the checksum, taken straight from the bus at capture.
  always_comb begin
    csum_in = HDR_BYTE ^ vad;
    for (int i = 0; i < NUM_GAINS; i++) begin
      csum_in = csum_in ^ gains[i*GAIN_W +: GAIN_W];
    end
  end

  // Checksum is latched together with the frame so later bus changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (load_frame) begin
      csum_q <= csum_in;
    end
  end
`endif

  // Ready is held low during reset and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  assign result_ready = rdy_en && (state == IDLE);
  assign busy         = (state != IDLE);
  assign baud_wrap    = (baud_cnt == BAUD_LAST);

  // FSM state and bit/byte counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
    end
  end

  // Frame buffer is written only on an accepted handshake; the bus is free afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vad_q   <= '0;
      gains_q <= '0;
    end else if (load_frame) begin
      vad_q   <= vad;
      gains_q <= gains;
    end
  end

  // Shift register holds the byte currently on the wire; reloaded as each start bit begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (load_shift) begin
      shift_q <= byte_sel;
    end
  end

  // Selects the packet byte for the index the FSM is about to enter. The header is a
  // constant, so byte 0 never depends on the buffer that is being loaded on the same edge.
  always_comb begin
    byte_sel = HDR_BYTE;
    if (byte_nx == BIDX_W'(1)) begin
      byte_sel = vad_q;
    end
    for (int i = 0; i < NUM_GAINS; i++) begin
      if (byte_nx == BIDX_W'(i + 2)) begin
        byte_sel = gains_q[i*GAIN_W +: GAIN_W];
      end
    end
`ifdef RNN_TX_CHECKSUM_EN
    if (byte_nx == BIDX_W'(NUM_DATA)) begin
      byte_sel = csum_q;
    end
`endif
  end

  // Next-state, counter updates and line/pulse outputs; each bit lasts exactly CLK_DIV cycles.
  always_comb begin
    state_nx   = state;
    baud_nx    = baud_cnt;
    bit_nx     = bit_idx;
    byte_nx    = byte_idx;
    load_frame = 1'b0;
    load_shift = 1'b0;
    frame_done = 1'b0;
    uart_tx    = 1'b1;

    case (state)
      IDLE: begin
        uart_tx = 1'b1;
        if (result_valid && result_ready) begin
          state_nx   = START;
          baud_nx    = '0;
          bit_nx     = '0;
          byte_nx    = '0;
          load_frame = 1'b1;
          load_shift = 1'b1;
        end
      end

      START: begin
        uart_tx = 1'b0;
        if (baud_wrap) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        uart_tx = shift_q[bit_idx];
        if (baud_wrap) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_nx = bit_idx + 1'b1;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        uart_tx = 1'b1;
        if (baud_wrap) begin
          baud_nx = '0;
          if (byte_idx == BYTE_LAST) begin
            // Pulse in the final stop-bit cycle; ready is still low, so no capture this cycle.
            frame_done = 1'b1;
            byte_nx    = '0;
            state_nx   = IDLE;
          end else begin
            byte_nx    = byte_idx + 1'b1;
            load_shift = 1'b1;
            state_nx   = START;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rnn_result_tx.sv
// Directed bench for rnn_result_tx at CLK_DIV=4: every line sample of each packet is
// recorded on the falling edge and compared against a bit-level expectation.
module tb_rnn_result_tx;

  localparam int         CLK_DIV   = 4;
  localparam int         NUM_GAINS = 22;
  localparam int         GAIN_W    = 8;
  localparam logic [7:0] HDR       = 8'hA5;
`ifdef RNN_TX_CHECKSUM_EN
  localparam int         NB        = NUM_GAINS + 3;
`else
  localparam int         NB        = NUM_GAINS + 2;
`endif
  localparam int         BT        = 10 * CLK_DIV;
  localparam int         PKT       = NB * BT;
  localparam int         DEPTH     = 2048;

  logic                        clk          = 1'b0;
  logic                        rst_n        = 1'b0;
  logic                        result_valid = 1'b0;
  logic                        result_ready;
  logic [NUM_GAINS*GAIN_W-1:0] gains        = '0;
  logic [GAIN_W-1:0]           vad          = '0;
  logic                        uart_tx;
  logic                        busy;
  logic                        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  logic       tx_s [0:DEPTH-1];
  logic       bz_s [0:DEPTH-1];
  logic       fd_s [0:DEPTH-1];
  logic       rd_s [0:DEPTH-1];
  logic [7:0] exp_b [0:NB-1];

  rnn_result_tx #(
    .CLK_DIV   (CLK_DIV),
    .NUM_GAINS (NUM_GAINS),
    .GAIN_W    (GAIN_W),
    .HDR_BYTE  (HDR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .gains        (gains),
    .vad          (vad),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gain_val(input int mode, input int i);
    case (mode)
      0:       return 8'(i + 1);
      1:       return 8'hFF;
      2:       return 8'(240 - i * 3);
      default: return 8'h5A;
    endcase
  endfunction

  task automatic set_bus(input logic [7:0] v, input int mode);
    vad = v;
    for (int i = 0; i < NUM_GAINS; i++) gains[i*GAIN_W +: GAIN_W] = gain_val(mode, i);
  endtask

  task automatic set_exp(input logic [7:0] v, input int mode);
    logic [7:0] x;
    exp_b[0] = HDR;
    exp_b[1] = v;
    for (int i = 0; i < NUM_GAINS; i++) exp_b[i+2] = gain_val(mode, i);
`ifdef RNN_TX_CHECKSUM_EN
    x = 8'h00;
    for (int b = 0; b < NB - 1; b++) x = x ^ exp_b[b];
    exp_b[NB-1] = x;
`else
    x = 8'h00;
`endif
  endtask

  task automatic sample(input int i);
    tx_s[i] = uart_tx;
    bz_s[i] = busy;
    fd_s[i] = frame_done;
    rd_s[i] = result_ready;
  endtask

  task automatic rec(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(i);
    end
  endtask

  // Must be called at a falling edge; returns #1 after the capturing rising edge.
  task automatic capture(input string tag);
    int t;
    t = 0;
    result_valid = 1'b1;
    while (result_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_wait"}, 32'(t < 50), 32'd1);
    @(posedge clk);
    #1;
    result_valid = 1'b0;
  endtask

  // sel 0: low line samples, 1: busy samples, 2: frame_done samples, over [lo, hi).
  function automatic int cnt(input int sel, input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi; i++) begin
      case (sel)
        0:       if (tx_s[i] === 1'b0) c++;
        1:       if (bz_s[i] === 1'b1) c++;
        default: if (fd_s[i] === 1'b1) c++;
      endcase
    end
    return c;
  endfunction

  function automatic logic [7:0] dec(input int base, input int b);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = tx_s[base + b*BT + (k+1)*CLK_DIV + CLK_DIV/2];
    return v;
  endfunction

  function automatic int frame_err(input int base);
    int  e;
    logic want;
    e = 0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 10; k++)
        for (int m = 0; m < CLK_DIV; m++) begin
          if (k == 0)      want = 1'b0;
          else if (k == 9) want = 1'b1;
          else             want = exp_b[b][k-1];
          if (tx_s[base + b*BT + k*CLK_DIV + m] !== want) e++;
        end
    return e;
  endfunction

  task automatic check_pkt(input string tag, input int base);
    for (int b = 0; b < NB; b++)
      chk($sformatf("%s_byte%0d", tag, b), 32'(dec(base, b)), 32'(exp_b[b]));
    chk({tag, "_framing"},    32'(frame_err(base)), 32'd0);
    chk({tag, "_done_pos"},   32'(fd_s[base + PKT - 1]), 32'd1);
    chk({tag, "_done_count"}, 32'(cnt(2, base, base + PKT)), 32'd1);
    chk({tag, "_busy_span"},  32'(cnt(1, base, base + PKT)), 32'(PKT));
    chk({tag, "_busy_after"}, 32'(bz_s[base + PKT]), 32'd0);
  endtask

  initial begin
    // Reset held for five cycles, then released on a falling edge.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx",    32'(uart_tx), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_ready", 32'(result_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(result_ready), 32'd1);
    chk("post_rst_tx",    32'(uart_tx), 32'd1);
    chk("post_rst_busy",  32'(busy), 32'd0);
    chk("post_rst_done",  32'(frame_done), 32'd0);

    // Single packet: vad 3C, gain i = i+1.
    set_bus(8'h3C, 0);
    set_exp(8'h3C, 0);
    capture("single");
    rec(PKT + 1);
    chk("single_first_start", 32'(tx_s[0]), 32'd0);
    check_pkt("single", 0);

    // Bit timing: vad 00 gives a 36-cycle low run, gain FF gives only the start bit low.
    set_bus(8'h00, 1);
    set_exp(8'h00, 1);
    capture("bits");
    rec(PKT + 1);
    check_pkt("bits", 0);
    chk("bits_vad_low",    32'(cnt(0, BT, 2*BT)), 32'(9 * CLK_DIV));
    chk("bits_vad_stop",   32'(cnt(0, 2*BT - CLK_DIV, 2*BT)), 32'd0);
    chk("bits_g0_low",     32'(cnt(0, 2*BT, 3*BT)), 32'(CLK_DIV));
    chk("bits_g0_start",   32'(cnt(0, 2*BT, 2*BT + CLK_DIV)), 32'(CLK_DIV));

    // Back-pressure: a mid-packet valid pulse is ignored; valid held across frame_done
    // is captured one cycle later and the next start bit follows one cycle after that.
    set_bus(8'h3C, 0);
    set_exp(8'h3C, 0);
    capture("bp");
    for (int i = 0; i < 2*PKT + 2; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 300) begin
        set_bus(8'hEE, 3);
        result_valid = 1'b1;
      end
      if (i == 320)     result_valid = 1'b0;
      if (i == PKT - 5) begin
        set_bus(8'h42, 2);
        result_valid = 1'b1;
      end
      if (i == PKT + 1) result_valid = 1'b0;
    end
    check_pkt("bp_a", 0);
    chk("bp_done_ready",   32'(rd_s[PKT - 1]), 32'd0);
    chk("bp_idle_ready",   32'(rd_s[PKT]), 32'd1);
    chk("bp_idle_tx",      32'(tx_s[PKT]), 32'd1);
    chk("bp_next_start",   32'(tx_s[PKT + 1]), 32'd0);
    chk("bp_next_busy",    32'(bz_s[PKT + 1]), 32'd1);
    set_exp(8'h42, 2);
    check_pkt("bp_b", PKT + 1);

    // Reset during a low data bit of byte 5 forces the line idle immediately.
    set_bus(8'h3C, 0);
    set_exp(8'h3C, 0);
    capture("mid");
    rec(5*BT + 2*CLK_DIV + 2);
    chk("mid_pre_tx",   32'(tx_s[5*BT + 2*CLK_DIV + 1]), 32'd0);
    chk("mid_pre_busy", 32'(bz_s[5*BT + 2*CLK_DIV + 1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",    32'(uart_tx), 32'd1);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(result_ready), 32'd0);
    chk("mid_rst_done",  32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_hold_tx",   32'(uart_tx), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(result_ready), 32'd1);
    set_bus(8'h11, 2);
    set_exp(8'h11, 2);
    capture("after");
    rec(PKT + 1);
    check_pkt("after", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
